auto_play_sequencer: RTL

AUTO_PLAY_SEQUENCER -- requirements
Module: auto_play_sequencer

---
 rtl/auto_play_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/auto_play_sequencer.sv
// Auto-play song sequencer: walks a song ROM and drives note/octave to the buzzer.
// Define LOOP_PLAY_EN to restart the song from entry 0 after completion instead of returning to IDLE.
module auto_play_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000,
  parameter int unsigned SONG_LEN    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       play_pulse,
  output logic [5:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [2:0] auto_note,
  output logic [1:0] auto_octave,
  output logic       playing,
  output logic       song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SOUND,
    S_GAP,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [5:0]  LAST_IDX = 6'(SONG_LEN - 1);
  localparam logic [31:0] GAP_LOAD = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

  state_t      r_state;
  state_t      r_held;
  logic [5:0]  r_idx;
  logic [31:0] r_cnt;
  logic [2:0]  r_note;
  logic [1:0]  r_octave;

  state_t      w_state_nxt;
  state_t      w_held_nxt;
  logic [5:0]  w_idx_nxt;
  logic [31:0] w_cnt_nxt;
  logic [2:0]  w_note_nxt;
  logic [1:0]  w_oct_nxt;

  state_t      w_run_state;
  logic [5:0]  w_run_idx;
  logic [31:0] w_run_cnt;
  logic [31:0] w_dur_cycles;

  assign w_dur_cycles = 32'(rom_data[2:0]) * 32'(BEAT_CYCLES) - 32'd1;

  // Where SOUND/GAP would go this cycle if undisturbed; a pause parks this result until resume.
  always_comb begin
    w_run_state = r_state;
    w_run_idx   = r_idx;
    w_run_cnt   = r_cnt - 32'd1;
    if (r_cnt == 32'd0) begin
      if (r_state == S_SOUND && GAP_CYCLES != 0) begin
        w_run_state = S_GAP;
        w_run_cnt   = GAP_LOAD;
      end else if (r_idx == LAST_IDX) begin
        w_run_state = S_DONE;
        w_run_cnt   = 32'd0;
      end else begin
        w_run_state = S_FETCH;
        w_run_idx   = r_idx + 6'd1;
        w_run_cnt   = 32'd0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_note_nxt  = r_note;
    w_oct_nxt   = r_octave;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 6'd0;
      w_cnt_nxt   = 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (play_pulse) w_state_nxt = S_FETCH;
        end
        S_FETCH: w_state_nxt = S_LOAD;
        S_LOAD: begin
          w_note_nxt = rom_data[5:3];
          w_oct_nxt  = rom_data[7:6];
          if (rom_data[2:0] == 3'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SOUND;
            w_cnt_nxt   = w_dur_cycles;
          end
        end
        S_SOUND, S_GAP: begin
          w_idx_nxt = w_run_idx;
          w_cnt_nxt = w_run_cnt;
          if (play_pulse) begin
            w_state_nxt = S_PAUSE;
            w_held_nxt  = w_run_state;
          end else begin
            w_state_nxt = w_run_state;
          end
        end
        S_PAUSE: begin
          if (play_pulse) w_state_nxt = r_held;
        end
        S_DONE: begin
          w_idx_nxt = 6'd0;
          w_cnt_nxt = 32'd0;
`ifdef LOOP_PLAY_EN
          w_state_nxt = S_FETCH;
`else
          w_state_nxt = S_IDLE;
`endif
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_held   <= S_IDLE;
      r_idx    <= 6'd0;
      r_cnt    <= 32'd0;
      r_note   <= 3'd0;
      r_octave <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_held   <= w_held_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_note   <= w_note_nxt;
      r_octave <= w_oct_nxt;
    end
  end

  assign rom_addr    = r_idx;
  assign auto_note   = (r_state == S_SOUND) ? r_note : 3'd0;
  assign auto_octave = r_octave;
  assign playing     = (r_state == S_FETCH) || (r_state == S_LOAD) ||
                       (r_state == S_SOUND) || (r_state == S_GAP);
  assign song_done   = (r_state == S_DONE);

endmodule
